div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum BUSY cycles allowed before abort.
REQ-003 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports reqN_valid  in  1  request from requester N (N=0,1).
REQ-006 SHALL have ports reqN_ready  out  1  request accepted this cycle.
REQ-007 SHALL have ports reqN_a, reqN_b  in  WIDTH  dividend, divisor.
REQ-008 SHALL have ports reqN_signed_a, reqN_signed_b  in  1  operand signedness.
REQ-009 SHALL have ports respN_valid  out  1  one-cycle result pulse.
REQ-010 SHALL have ports respN_quotient, respN_remainder  out  WIDTH  result.
REQ-011 SHALL have ports respN_error  out  1  timeout abort flag, valid with respN_valid.
REQ-012 SHALL have ports div_input_a, div_input_b  out  WIDTH  divider operands.
REQ-013 SHALL have ports div_signed_a, div_signed_b  out  1  divider signedness.
REQ-014 SHALL have port div_enable  out  1  divider start/hold.
REQ-015 SHALL have ports div_quotient, div_remainder  in  WIDTH  divider results.
REQ-016 SHALL have port div_data_valid  in  1  divider result valid.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-018 SHALL assert reqN_ready combinationally only in IDLE, only for the granted port, and only while reqN_valid=1.
REQ-019 SHALL grant round-robin: if both request in IDLE, the port not granted last wins; a lone requester always wins.
REQ-020 SHALL require requesters to hold valid and operands stable until accepted.
REQ-021 SHALL on acceptance at cycle T register operands, signs and owner, and enter BUSY at T+1.
REQ-022 SHALL in BUSY drive div_enable=1 with the registered operands held stable.
REQ-023 SHALL count BUSY cycles from 0.
REQ-024 SHALL on div_data_valid=1 in BUSY capture quotient/remainder and enter RESP.
REQ-025 SHALL on count=TIMEOUT-1 without div_data_valid enter RESP with error=1, quotient=0, remainder=0.
REQ-026 SHALL if div_data_valid=1 and count=TIMEOUT-1 in the same cycle treat it as success.
REQ-027 SHALL in RESP pulse respN_valid for the owner only, drive div_enable=0, and return to IDLE next cycle.
REQ-028 SHALL guarantee div_enable=0 for at least one cycle between operations, as required for divider restart.
REQ-029 SHALL ignore div_data_valid outside BUSY.
REQ-030 SHALL pass divide-by-zero to the divider unchanged and forward its result.
REQ-031 SHALL hold respN outputs at 0 whenever respN_valid=0.

Reset
REQ-032 SHALL on reset_n=0 immediately force IDLE, div_enable=0, all reqN_ready/respN_valid/respN_error=0, and all data outputs and counters to 0.
REQ-033 SHALL reset the last-grant register to port 1, so port 0 wins the first contention.
REQ-034 SHALL on reset during BUSY or RESP discard the operation with no response; requesters re-issue.

Configuration
REQ-035 SHALL use macro DIV_ARB_CACHE_EN to control the result cache.
REQ-036 SHALL when DIV_ARB_CACHE_EN is defined keep the last successful operands, signs and result with a valid bit, cleared by reset.
REQ-037 SHALL when DIV_ARB_CACHE_EN is defined, on an accepted request exactly matching the cache, go IDLE->RESP at T+1 with the cached result and keep div_enable=0 throughout.
REQ-038 SHALL when DIV_ARB_CACHE_EN is defined not update the cache on timeout.
REQ-039 SHALL when DIV_ARB_CACHE_EN is not defined send every request to the divider and contain no cache storage.

Verification
REQ-040 Single op: req0 a=15634654, b=21354, unsigned -> div_enable at T+1; resp0_valid one cycle after div_data_valid with quotient=732, remainder=3526, error=0.
REQ-041 Contention: req0 and req1 both valid after reset -> port 0 served first, then port 1; next contention goes to port 0; div_enable low for at least 1 cycle between ops.
REQ-042 Timeout: div_data_valid tied 0, req1 a=100, b=7 -> resp1_valid at T+1+64 with error=1, quotient=0, remainder=0.
REQ-043 Reset mid-op: reset_n low 5 cycles into BUSY -> div_enable=0 immediately; no respN_valid; after release the next request is served normally.
REQ-044 Cache: with DIV_ARB_CACHE_EN, repeat the REQ-040 op -> resp0_valid at T+1 with 732/3526 and div_enable never high; without the macro, full divider latency.
REQ-045 Signed: a=-100, b=7, both signed -> output equals the divider's quotient -14, remainder -2, passed through unchanged.

Source files
------------

// File: rtl/div_arbiter.sv
// Two-port round-robin front end for a shared multi-cycle divider, with a per-operation timeout abort.
// Optional last-result cache enabled by defining DIV_ARB_CACHE_EN.
module div_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_signed_a,
  input  logic             req0_signed_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_signed_a,
  input  logic             req1_signed_b,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_quotient,
  output logic [WIDTH-1:0] resp0_remainder,
  output logic             resp0_error,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_quotient,
  output logic [WIDTH-1:0] resp1_remainder,
  output logic             resp1_error,
  output logic [WIDTH-1:0] div_input_a,
  output logic [WIDTH-1:0] div_input_b,
  output logic             div_signed_a,
  output logic             div_signed_b,
  output logic             div_enable,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic             div_data_valid
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] busy_cnt;
  logic [WIDTH-1:0] op_a, op_b, res_q, res_r;
  logic             op_sa, op_sb, res_err;

  logic             grant, accept, cache_hit;
  logic [WIDTH-1:0] sel_a, sel_b, cache_q, cache_r;
  logic             sel_sa, sel_sb;

  // Round-robin: on contention the port not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;

  assign sel_a  = grant ? req1_a        : req0_a;
  assign sel_b  = grant ? req1_b        : req0_b;
  assign sel_sa = grant ? req1_signed_a : req0_signed_a;
  assign sel_sb = grant ? req1_signed_b : req0_signed_b;

`ifdef DIV_ARB_CACHE_EN
  logic             cache_vld;
  logic [WIDTH-1:0] cache_a, cache_b;
  logic             cache_sa, cache_sb;

  assign cache_hit = cache_vld && (cache_a == sel_a) && (cache_b == sel_b) &&
                     (cache_sa == sel_sa) && (cache_sb == sel_sb);

  // Only divider successes are remembered; timeouts leave the cache untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cache_vld <= 1'b0;
      cache_a   <= '0;
      cache_b   <= '0;
      cache_sa  <= 1'b0;
      cache_sb  <= 1'b0;
      cache_q   <= '0;
      cache_r   <= '0;
    end else if (state == BUSY && div_data_valid) begin
      cache_vld <= 1'b1;
      cache_a   <= op_a;
      cache_b   <= op_b;
      cache_sa  <= op_sa;
      cache_sb  <= op_sb;
      cache_q   <= div_quotient;
      cache_r   <= div_remainder;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_q   = '0;
  assign cache_r   = '0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      busy_cnt   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_sa      <= 1'b0;
      op_sb      <= 1'b0;
      res_q      <= '0;
      res_r      <= '0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            op_a       <= sel_a;
            op_b       <= sel_b;
            op_sa      <= sel_sa;
            op_sb      <= sel_sb;
            busy_cnt   <= '0;
            if (cache_hit) begin
              res_q   <= cache_q;
              res_r   <= cache_r;
              res_err <= 1'b0;
              state   <= RESP;
            end else begin
              state <= BUSY;
            end
          end
        end
        // A result arriving on the final allowed cycle still counts as success.
        BUSY: begin
          if (div_data_valid) begin
            res_q   <= div_quotient;
            res_r   <= div_remainder;
            res_err <= 1'b0;
            state   <= RESP;
          end else if (busy_cnt == CNT_LAST) begin
            res_q   <= '0;
            res_r   <= '0;
            res_err <= 1'b1;
            state   <= RESP;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        RESP: begin
          busy_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RESP always leaves the divider disabled for at least one cycle before the next start.
  assign div_enable   = (state == BUSY);
  assign div_input_a  = op_a;
  assign div_input_b  = op_b;
  assign div_signed_a = op_sa;
  assign div_signed_b = op_sb;

  assign resp0_valid     = (state == RESP) && !owner;
  assign resp1_valid     = (state == RESP) && owner;
  assign resp0_quotient  = resp0_valid ? res_q : '0;
  assign resp0_remainder = resp0_valid ? res_r : '0;
  assign resp0_error     = resp0_valid && res_err;
  assign resp1_quotient  = resp1_valid ? res_q : '0;
  assign resp1_remainder = resp1_valid ? res_r : '0;
  assign resp1_error     = resp1_valid && res_err;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: the bench plays the divider and supplies hand-computed results.
module tb_div_arbiter;
  localparam int WIDTH = 32;
  localparam int TIMEOUT = 64;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic req0_valid = 0, req0_signed_a = 0, req0_signed_b = 0;
  logic req1_valid = 0, req1_signed_a = 0, req1_signed_b = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready;
  logic resp0_valid, resp0_error, resp1_valid, resp1_error;
  logic [31:0] resp0_quotient, resp0_remainder, resp1_quotient, resp1_remainder;
  logic [31:0] div_input_a, div_input_b;
  logic div_signed_a, div_signed_b, div_enable;
  logic [31:0] div_quotient = 0, div_remainder = 0;
  logic div_data_valid = 0;

  int n_checks = 0;
  int n_fail = 0;

  div_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_signed_a(req0_signed_a), .req0_signed_b(req0_signed_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_signed_a(req1_signed_a), .req1_signed_b(req1_signed_b),
    .resp0_valid(resp0_valid), .resp0_quotient(resp0_quotient),
    .resp0_remainder(resp0_remainder), .resp0_error(resp0_error),
    .resp1_valid(resp1_valid), .resp1_quotient(resp1_quotient),
    .resp1_remainder(resp1_remainder), .resp1_error(resp1_error),
    .div_input_a(div_input_a), .div_input_b(div_input_b),
    .div_signed_a(div_signed_a), .div_signed_b(div_signed_b), .div_enable(div_enable),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_data_valid(div_data_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input bit port, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input bit sa, input bit sb);
    if (port) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_signed_a = sa; req1_signed_b = sb;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_signed_a = sa; req0_signed_b = sb;
    end
  endtask

  // Full uncached operation on one port; divider answers after lat extra BUSY cycles.
  task automatic do_op(input string tag, input bit port, input logic [31:0] a, input logic [31:0] b,
                       input bit sa, input bit sb, input int lat,
                       input logic [31:0] q, input logic [31:0] r);
    set_req(port, 1'b1, a, b, sa, sb);
    #1;
    check({tag, "_ready"}, 32'(port ? req1_ready : req0_ready), 32'd1);
    tick;
    set_req(port, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check({tag, "_en"}, 32'(div_enable), 32'd1);
    check({tag, "_in_a"}, div_input_a, a);
    check({tag, "_in_b"}, div_input_b, b);
    check({tag, "_sgn"}, {30'd0, div_signed_a, div_signed_b}, {30'd0, sa, sb});
    repeat (lat) tick;
    check({tag, "_en_hold"}, 32'(div_enable), 32'd1);
    div_data_valid = 1'b1; div_quotient = q; div_remainder = r;
    tick;
    div_data_valid = 1'b0; div_quotient = 32'd0; div_remainder = 32'd0;
    check({tag, "_vld"}, {30'd0, resp1_valid, resp0_valid}, port ? 32'd2 : 32'd1);
    check({tag, "_q"}, port ? resp1_quotient : resp0_quotient, q);
    check({tag, "_r"}, port ? resp1_remainder : resp0_remainder, r);
    check({tag, "_err"}, 32'(port ? resp1_error : resp0_error), 32'd0);
    check({tag, "_en_resp"}, 32'(div_enable), 32'd0);
    tick;
    check({tag, "_vld_off"}, {30'd0, resp1_valid, resp0_valid}, 32'd0);
    check({tag, "_q_off"}, port ? resp1_quotient : resp0_quotient, 32'd0);
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  initial begin
    int n;
    repeat (3) tick;
    check("rst_en", 32'(div_enable), 32'd0);
    check("rst_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst_vld", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    check("rst_in_a", div_input_a, 32'd0);
    check("rst_q", resp0_quotient, 32'd0);
    reset_n = 1'b1;
    tick;

    // Single unsigned operation, then the same operands again
    do_op("single", 1'b0, 32'd15634654, 32'd21354, 1'b0, 1'b0, 3, 32'd732, 32'd3526);
`ifdef DIV_ARB_CACHE_EN
    set_req(1'b0, 1'b1, 32'd15634654, 32'd21354, 1'b0, 1'b0);
    #1;
    check("cache_ready", 32'(req0_ready), 32'd1);
    tick;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("cache_en", 32'(div_enable), 32'd0);
    check("cache_vld", 32'(resp0_valid), 32'd1);
    check("cache_q", resp0_quotient, 32'd732);
    check("cache_r", resp0_remainder, 32'd3526);
    tick;
    check("cache_en_after", 32'(div_enable), 32'd0);
`else
    do_op("repeat", 1'b0, 32'd15634654, 32'd21354, 1'b0, 1'b0, 3, 32'd732, 32'd3526);
`endif

    // Divider results presented outside BUSY are ignored
    div_data_valid = 1'b1; div_quotient = 32'd5;
    tick;
    div_data_valid = 1'b0; div_quotient = 32'd0;
    check("stray_dv", {30'd0, resp1_valid, resp0_valid}, 32'd0);

    // Contention after reset: port 0, then port 1, then port 0 again
    apply_reset;
    set_req(1'b0, 1'b1, 32'd40, 32'd5, 1'b0, 1'b0);
    set_req(1'b1, 1'b1, 32'd90, 32'd9, 1'b0, 1'b0);
    #1;
    check("cont1_rdy", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("cont1_in_a", div_input_a, 32'd40);
    check("cont1_busy_rdy", 32'(req1_ready), 32'd0);
    tick;
    div_data_valid = 1'b1; div_quotient = 32'd8; div_remainder = 32'd0;
    tick;
    div_data_valid = 1'b0;
    check("cont1_vld", {30'd0, resp1_valid, resp0_valid}, 32'd1);
    check("cont1_q", resp0_quotient, 32'd8);
    check("cont1_gap_resp", 32'(div_enable), 32'd0);
    tick;
    check("cont1_gap_idle", 32'(div_enable), 32'd0);
    check("cont2_rdy", {30'd0, req1_ready, req0_ready}, 32'd2);
    tick;
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("cont2_en", 32'(div_enable), 32'd1);
    check("cont2_in_a", div_input_a, 32'd90);
    div_data_valid = 1'b1; div_quotient = 32'd10; div_remainder = 32'd0;
    tick;
    div_data_valid = 1'b0;
    check("cont2_vld", {30'd0, resp1_valid, resp0_valid}, 32'd2);
    check("cont2_q", resp1_quotient, 32'd10);
    tick;
    set_req(1'b0, 1'b1, 32'd7, 32'd2, 1'b0, 1'b0);
    set_req(1'b1, 1'b1, 32'd9, 32'd4, 1'b0, 1'b0);
    #1;
    check("cont3_rdy", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("cont3_in_a", div_input_a, 32'd7);
    div_data_valid = 1'b1; div_quotient = 32'd3; div_remainder = 32'd1;
    tick;
    div_data_valid = 1'b0;
    check("cont3_vld", {30'd0, resp1_valid, resp0_valid}, 32'd1);
    tick;

    // Timeout: divider never answers
    set_req(1'b1, 1'b1, 32'd100, 32'd7, 1'b0, 1'b0);
    #1;
    check("to_ready", 32'(req1_ready), 32'd1);
    tick;
    set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    n = 1;
    while (!resp1_valid && n < 100) begin
      tick;
      n++;
    end
    check("to_latency", 32'(n), 32'd65);
    check("to_err", 32'(resp1_error), 32'd1);
    check("to_q", resp1_quotient, 32'd0);
    check("to_r", resp1_remainder, 32'd0);
    check("to_en", 32'(div_enable), 32'd0);
    tick;

    // Reset in the middle of BUSY
    set_req(1'b0, 1'b1, 32'd1000, 32'd10, 1'b0, 1'b0);
    #1;
    tick;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (5) tick;
    check("mid_en_before", 32'(div_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_en_async", 32'(div_enable), 32'd0);
    check("mid_in_a", div_input_a, 32'd0);
    tick;
    check("mid_no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    reset_n = 1'b1;
    tick;
    check("mid_no_resp_post", {30'd0, resp1_valid, resp0_valid}, 32'd0);

    // Signed and divide-by-zero results pass through unchanged
    do_op("signed", 1'b0, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 4, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    do_op("divzero", 1'b1, 32'd55, 32'd0, 1'b0, 1'b0, 2, 32'hFFFF_FFFF, 32'd55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
